// File: rtl/calc_keypad_alu.sv
// Keypad calculator core: debounces a one-hot key vector, builds decimal operands
// A/B and evaluates + - * in one cycle or / by restoring division.
//   state    | meaning
//   ENTER_A  | accumulating operand A digits
//   ENTER_B  | operator latched, accumulating operand B digits (division runs here)
//   SHOW_RES | result valid
//   ERROR    | divide by zero, only clear exits
module calc_keypad_alu #(
  parameter int DIGITS    = 4,
  parameter int OPW       = 14,
  parameter int TICK_DIV  = 5,
  parameter int DEB_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      key,
  output logic [OPW-1:0]   opa,
  output logic [OPW-1:0]   opb,
  output logic [1:0]       op,
  output logic [2*OPW-1:0] result,
  output logic [OPW-1:0]   remainder,
  output logic [1:0]       mode,
  output logic             result_valid,
  output logic             busy,
  output logic             err,
  output logic             key_evt
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int RW = 2 * OPW;
  localparam int KW = $clog2(OPW + 1);
  localparam logic [RW-1:0] MAXV = RW'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {ENTER_A = 2'd0, ENTER_B = 2'd1, SHOW_RES = 2'd2, ERROR = 2'd3} mode_t;
  mode_t state;

  logic [TW-1:0]  tick_cnt;
  logic [15:0]    key_s;
  logic [DW-1:0]  deb_cnt, deb_next;
  logic           armed, tick, onehot, accept, rearm;
  logic [CW-1:0]  cnt_a, cnt_b;
  logic [3:0]     dig;
  logic [1:0]     op_key;
  logic [OPW-1:0] acc_a, acc_b;
  logic [RW-1:0]  ext_a, ext_b;
  logic [KW-1:0]  div_cnt;
  logic [OPW-1:0] div_r, div_q, r_new, q_new;
  logic [OPW:0]   r_sh, r_diff;
  logic           ge;

  assign mode         = state;
  assign result_valid = (state == SHOW_RES);
  assign err          = (state == ERROR);

  always_comb begin
    tick     = (tick_cnt == TW'(TICK_DIV - 1));
    deb_next = DW'(1);
    if (key == key_s)
      deb_next = (deb_cnt == DW'(DEB_TICKS)) ? deb_cnt : deb_cnt + DW'(1);
    onehot = (key != 16'd0) && ((key & (key - 16'd1)) == 16'd0);
    accept = tick && armed && onehot && (deb_next == DW'(DEB_TICKS));
    rearm  = tick && (key == 16'd0) && (deb_next == DW'(DEB_TICKS));
    dig = 4'd0;
    for (int i = 0; i < 10; i++)
      if (key[i]) dig = 4'(i);
    op_key = key[13] ? 2'd3 : key[12] ? 2'd2 : key[11] ? 2'd1 : 2'd0;
    acc_a = opa * OPW'(10) + OPW'(dig);
    acc_b = opb * OPW'(10) + OPW'(dig);
    ext_a = RW'(opa);
    ext_b = RW'(opb);
    // one restoring-division step: shift in next dividend bit, subtract if it fits
    r_sh   = {div_r, div_q[OPW-1]};
    r_diff = r_sh - {1'b0, opb};
    ge     = (r_sh >= {1'b0, opb});
    r_new  = ge ? r_diff[OPW-1:0] : r_sh[OPW-1:0];
    q_new  = {div_q[OPW-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt  <= '0;
      key_s     <= '0;
      deb_cnt   <= '0;
      armed     <= 1'b1;
      key_evt   <= 1'b0;
      state     <= ENTER_A;
      opa       <= '0;
      opb       <= '0;
      op        <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      result    <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      div_cnt   <= '0;
      div_r     <= '0;
      div_q     <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      key_evt  <= accept;
      if (tick) begin
        key_s   <= key;
        deb_cnt <= deb_next;
        if (accept)     armed <= 1'b0;
        else if (rearm) armed <= 1'b1;
      end
      if (busy) begin
        div_r   <= r_new;
        div_q   <= q_new;
        div_cnt <= div_cnt - KW'(1);
        if (div_cnt == KW'(1)) begin
          busy      <= 1'b0;
          result    <= RW'(q_new);
          remainder <= r_new;
          state     <= SHOW_RES;
        end
      end
      if (accept) begin
        if (key[15]) begin
          state     <= ENTER_A;
          opa       <= '0;
          opb       <= '0;
          op        <= '0;
          cnt_a     <= '0;
          cnt_b     <= '0;
          result    <= '0;
          remainder <= '0;
          busy      <= 1'b0;
          div_cnt   <= '0;
          div_r     <= '0;
          div_q     <= '0;
        end else if (!busy) begin
          case (state)
            ENTER_A: begin
              if (|key[9:0]) begin
                if (cnt_a < CW'(DIGITS)) begin
                  opa   <= acc_a;
                  cnt_a <= cnt_a + CW'(1);
                end
              end else if (|key[13:10]) begin
                op    <= op_key;
                opb   <= '0;
                cnt_b <= '0;
                state <= ENTER_B;
              end
            end
            ENTER_B: begin
              if (|key[9:0]) begin
                if (cnt_b < CW'(DIGITS)) begin
                  opb   <= acc_b;
                  cnt_b <= cnt_b + CW'(1);
                end
              end else if (|key[13:10]) begin
                if (cnt_b == '0) op <= op_key;
              end else if (key[14]) begin
                if (op != 2'd3) begin
                  result    <= (op == 2'd0) ? ext_a + ext_b :
                               (op == 2'd1) ? ext_a - ext_b : ext_a * ext_b;
                  remainder <= '0;
                  state     <= SHOW_RES;
                end else if (opb == '0) begin
                  state <= ERROR;
                end else begin
                  busy    <= 1'b1;
                  div_cnt <= KW'(OPW);
                  div_r   <= '0;
                  div_q   <= opa;
                end
              end
            end
            SHOW_RES: begin
              if (|key[9:0]) begin
                opa       <= OPW'(dig);
                cnt_a     <= CW'(1);
                opb       <= '0;
                cnt_b     <= '0;
                result    <= '0;
                remainder <= '0;
                state     <= ENTER_A;
              end else if (|key[13:10]) begin
                if (!result[RW-1] && result <= MAXV) begin
                  opa   <= result[OPW-1:0];
                  op    <= op_key;
                  opb   <= '0;
                  cnt_b <= '0;
                  state <= ENTER_B;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_calc_keypad_alu.sv
// Directed bench for calc_keypad_alu; a short tick/debounce setting lets a key be
// accepted within the division window.
module tb_calc_keypad_alu;
  localparam int DIGITS = 4, OPW = 14, TICK_DIV = 2, DEB_TICKS = 2;
  localparam int HOLD = 2 * DEB_TICKS * TICK_DIV * 2;
  localparam logic [15:0] K_ADD = 16'h0400, K_SUB = 16'h0800, K_MUL = 16'h1000,
                          K_DIV = 16'h2000, K_EQ = 16'h4000, K_CLR = 16'h8000;

  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] key = 16'd0;
  logic [OPW-1:0] opa, opb, remainder;
  logic [1:0] op, mode;
  logic [2*OPW-1:0] result;
  logic result_valid, busy, err, key_evt;
  int checks = 0, errors = 0;
  int evt_count = 0, busy_cycles = 0;

  calc_keypad_alu #(.DIGITS(DIGITS), .OPW(OPW), .TICK_DIV(TICK_DIV), .DEB_TICKS(DEB_TICKS)) dut (
    .clk(clk), .rst(rst), .key(key), .opa(opa), .opb(opb), .op(op), .result(result),
    .remainder(remainder), .mode(mode), .result_valid(result_valid), .busy(busy),
    .err(err), .key_evt(key_evt));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (key_evt === 1'b1) evt_count++;
    if (busy === 1'b1) busy_cycles++;
  end

  function automatic logic [15:0] dk(input int d);
    return 16'(1 << d);
  endfunction

  task automatic press(input logic [15:0] k);
    @(negedge clk); key = k;
    repeat (HOLD) @(negedge clk);
    key = 16'd0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic test_reset;
    #23;
    checks++; if (opa !== 0 || opb !== 0 || op !== 0) begin errors++; $display("FAIL reset_ops opa=%0d opb=%0d op=%0d expected 0", opa, opb, op); end
    checks++; if (result !== 0 || remainder !== 0) begin errors++; $display("FAIL reset_result got %0h/%0h expected 0", result, remainder); end
    checks++; if (mode !== 0 || result_valid !== 0 || busy !== 0 || err !== 0 || key_evt !== 0) begin errors++; $display("FAIL reset_status mode=%0d rv=%b busy=%b err=%b evt=%b expected 0", mode, result_valid, busy, err, key_evt); end
    @(negedge clk); rst = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_add_chain;
    int e0;
    e0 = evt_count;
    press(dk(1)); press(dk(2)); press(dk(3)); press(K_ADD);
    press(dk(4)); press(dk(5)); press(K_EQ);
    checks++; if (opa !== 123 || opb !== 45) begin errors++; $display("FAIL add_operands got %0d,%0d expected 123,45", opa, opb); end
    checks++; if (result !== 168) begin errors++; $display("FAIL add_result got %0d expected 168", result); end
    checks++; if (mode !== 2 || result_valid !== 1) begin errors++; $display("FAIL add_mode got %0d/%b expected 2/1", mode, result_valid); end
    checks++; if (evt_count - e0 !== 7) begin errors++; $display("FAIL add_evts got %0d expected 7", evt_count - e0); end
    press(K_MUL); press(dk(2)); press(K_EQ);
    checks++; if (opa !== 168 || op !== 2 || result !== 336) begin errors++; $display("FAIL chain_mul opa=%0d op=%0d result=%0d expected 168,2,336", opa, op, result); end
    press(K_CLR);
  endtask

  task automatic test_digit_limit;
    int e0;
    e0 = evt_count;
    for (int i = 0; i < 5; i++) press(dk(9));
    checks++; if (opa !== 9999) begin errors++; $display("FAIL digit_limit got %0d expected 9999", opa); end
    checks++; if (evt_count - e0 !== 5) begin errors++; $display("FAIL digit_limit_evts got %0d expected 5", evt_count - e0); end
    press(K_CLR);
  endtask

  task automatic test_sub_negative;
    press(dk(7)); press(K_SUB); press(dk(2)); press(dk(0)); press(K_EQ);
    checks++; if (result !== 28'hFFFFFF3) begin errors++; $display("FAIL sub_neg got %0h expected ffffff3", result); end
    press(K_ADD);
    checks++; if (mode !== 2 || opa !== 7 || op !== 1) begin errors++; $display("FAIL sub_op_ignored mode=%0d opa=%0d op=%0d expected 2,7,1", mode, opa, op); end
    press(dk(6));
    checks++; if (mode !== 0 || opa !== 6 || result !== 0) begin errors++; $display("FAIL new_calc mode=%0d opa=%0d result=%0d expected 0,6,0", mode, opa, result); end
    press(K_CLR);
  endtask

  task automatic test_divide;
    int t;
    press(dk(1)); press(dk(0)); press(dk(0)); press(K_DIV); press(dk(7));
    busy_cycles = 0;
    @(negedge clk); key = K_EQ;
    t = 0;
    while (key_evt !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    key = 16'd0;
    repeat (5) @(negedge clk);
    key = dk(3);
    t = 0;
    while (key_evt !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_key_while_busy busy=%b expected 1", busy); end
    key = 16'd0;
    repeat (HOLD * 2) @(negedge clk);
    checks++; if (busy_cycles !== 14) begin errors++; $display("FAIL div_busy_cycles got %0d expected 14", busy_cycles); end
    checks++; if (result !== 14 || remainder !== 2) begin errors++; $display("FAIL div_result got %0d r %0d expected 14 r 2", result, remainder); end
    checks++; if (opb !== 7 || mode !== 2 || busy !== 0) begin errors++; $display("FAIL div_state opb=%0d mode=%0d busy=%b expected 7,2,0", opb, mode, busy); end
    press(K_CLR);
  endtask

  task automatic test_div_zero;
    press(dk(5)); press(K_DIV); press(dk(0)); press(K_EQ);
    checks++; if (mode !== 3 || err !== 1) begin errors++; $display("FAIL div0_err mode=%0d err=%b expected 3,1", mode, err); end
    press(dk(4));
    checks++; if (mode !== 3 || opb !== 0) begin errors++; $display("FAIL div0_digit mode=%0d opb=%0d expected 3,0", mode, opb); end
    press(K_CLR);
    checks++; if (opa !== 0 || op !== 0 || mode !== 0 || err !== 0 || result !== 0) begin errors++; $display("FAIL clear opa=%0d op=%0d mode=%0d err=%b result=%0d expected 0", opa, op, mode, err, result); end
  endtask

  task automatic test_glitch;
    int e0;
    e0 = evt_count;
    for (int i = 0; i < 12; i++) begin
      key = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      repeat (TICK_DIV) @(negedge clk);
    end
    key = 16'h0003;
    repeat (HOLD * 2) @(negedge clk);
    key = 16'd0;
    repeat (HOLD) @(negedge clk);
    checks++; if (evt_count - e0 !== 0) begin errors++; $display("FAIL glitch_evts got %0d expected 0", evt_count - e0); end
    checks++; if (opa !== 0 || mode !== 0) begin errors++; $display("FAIL glitch_state opa=%0d mode=%0d expected 0,0", opa, mode); end
  endtask

  task automatic test_reset_mid_div;
    int t;
    press(dk(9)); press(K_DIV); press(dk(2));
    @(negedge clk); key = K_EQ;
    t = 0;
    while (busy !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_div_start busy=%b expected 1", busy); end
    #1 rst = 1'b0;
    #1;
    checks++; if (busy !== 0 || opa !== 0 || opb !== 0 || op !== 0 || result !== 0 || mode !== 0) begin errors++; $display("FAIL rst_mid_div busy=%b opa=%0d opb=%0d op=%0d result=%0d mode=%0d expected 0", busy, opa, opb, op, result, mode); end
    key = 16'd0;
    repeat (HOLD) @(negedge clk);
    checks++; if (result !== 0 || remainder !== 0 || mode !== 0) begin errors++; $display("FAIL rst_no_partial result=%0d rem=%0d mode=%0d expected 0", result, remainder, mode); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add_chain;
    test_digit_limit;
    test_sub_negative;
    test_divide;
    test_div_zero;
    test_glitch;
    test_reset_mid_div;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
